// File: rtl/pipeline_carry_skip_subtractor.sv
// Three-stage pipelined 64-bit subtractor (a - b - bin) built from carry-skip blocks,
// with a valid/ready handshake that stalls the whole pipe under output backpressure.
module pipeline_carry_skip_subtractor #(
    parameter int width = 64,
    parameter int blk   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int S1_W = 24;
    localparam int S2_W = 24;
    localparam int S3_W = 16;
    localparam int HI1_W = S2_W + S3_W;

    // One carry-skip block: ripple sum, but a fully propagating block forwards its carry-in.
    function automatic logic [blk:0] csk_block(
        input logic [blk-1:0] x,
        input logic [blk-1:0] y,
        input logic           cin
    );
        logic [blk:0]   c;
        logic [blk-1:0] p;
        logic [blk-1:0] s;
        c    = {(blk+1){1'b0}};
        p    = {blk{1'b0}};
        s    = {blk{1'b0}};
        c[0] = cin;
        for (int i = 0; i < blk; i++) begin
            p[i]   = x[i] ^ y[i];
            s[i]   = p[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (p[i] & c[i]);
        end
        return {((&p) ? cin : c[blk]), s};
    endfunction

    function automatic logic [S1_W:0] csk_slice24(
        input logic [S1_W-1:0] x,
        input logic [S1_W-1:0] y,
        input logic            cin
    );
        logic [blk:0]    br;
        logic [S1_W-1:0] s;
        logic            carry;
        carry = cin;
        s     = {S1_W{1'b0}};
        br    = {(blk+1){1'b0}};
        for (int k = 0; k < S1_W / blk; k++) begin
            br                = csk_block(x[k*blk +: blk], y[k*blk +: blk], carry);
            s[k*blk +: blk]   = br[blk-1:0];
            carry             = br[blk];
        end
        return {carry, s};
    endfunction

    function automatic logic [S3_W:0] csk_slice16(
        input logic [S3_W-1:0] x,
        input logic [S3_W-1:0] y,
        input logic            cin
    );
        logic [blk:0]    br;
        logic [S3_W-1:0] s;
        logic            carry;
        carry = cin;
        s     = {S3_W{1'b0}};
        br    = {(blk+1){1'b0}};
        for (int k = 0; k < S3_W / blk; k++) begin
            br                = csk_block(x[k*blk +: blk], y[k*blk +: blk], carry);
            s[k*blk +: blk]   = br[blk-1:0];
            carry             = br[blk];
        end
        return {carry, s};
    endfunction

    logic                      w_en;
    logic [S1_W:0]             w_s1;
    logic [S2_W:0]             w_s2;
    logic [S3_W:0]             w_s3;
    logic [width-1:0]          w_nb;
    logic                      w_ovf;

    logic                      r1_v;
    logic                      r1_c;
    logic [S1_W-1:0]           r1_diff;
    logic [HI1_W-1:0]          r1_a_hi;
    logic [HI1_W-1:0]          r1_nb_hi;

    logic                      r2_v;
    logic                      r2_c;
    logic [S1_W+S2_W-1:0]      r2_diff;
    logic [S3_W-1:0]           r2_a_hi;
    logic [S3_W-1:0]           r2_nb_hi;

    logic                      r_out_valid;
    logic [width-1:0]          r_diff;
    logic                      r_bout;
    logic                      r_ovf;

    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en;

    // Subtraction is a + ~b + ~bin; the inverted borrow-in seeds the carry chain.
    assign w_nb = ~b;
    assign w_s1 = csk_slice24(a[S1_W-1:0], w_nb[S1_W-1:0], ~bin);
    assign w_s2 = csk_slice24(r1_a_hi[S2_W-1:0], r1_nb_hi[S2_W-1:0], r1_c);
    assign w_s3 = csk_slice16(r2_a_hi, r2_nb_hi, r2_c);

    // Signed overflow: operands differ in sign and the result sign differs from a's.
    assign w_ovf = (r2_a_hi[S3_W-1] != ~r2_nb_hi[S3_W-1]) & (w_s3[S3_W-1] != r2_a_hi[S3_W-1]);

    // Stage 1: low 24 bits, forward the untouched upper operand bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_v     <= 1'b0;
            r1_c     <= 1'b0;
            r1_diff  <= {S1_W{1'b0}};
            r1_a_hi  <= {HI1_W{1'b0}};
            r1_nb_hi <= {HI1_W{1'b0}};
        end else if (w_en) begin
            r1_v     <= in_valid;
            r1_c     <= w_s1[S1_W];
            r1_diff  <= w_s1[S1_W-1:0];
            r1_a_hi  <= a[width-1:S1_W];
            r1_nb_hi <= w_nb[width-1:S1_W];
        end
    end

    // Stage 2: middle 24 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_v     <= 1'b0;
            r2_c     <= 1'b0;
            r2_diff  <= {(S1_W+S2_W){1'b0}};
            r2_a_hi  <= {S3_W{1'b0}};
            r2_nb_hi <= {S3_W{1'b0}};
        end else if (w_en) begin
            r2_v     <= r1_v;
            r2_c     <= w_s2[S2_W];
            r2_diff  <= {w_s2[S2_W-1:0], r1_diff};
            r2_a_hi  <= r1_a_hi[HI1_W-1:S2_W];
            r2_nb_hi <= r1_nb_hi[HI1_W-1:S2_W];
        end
    end

    // Stage 3: top 16 bits and final flags, driving the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_diff      <= {width{1'b0}};
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r2_v;
            r_diff      <= {w_s3[S3_W-1:0], r2_diff};
            r_bout      <= ~w_s3[S3_W];
            r_ovf       <= w_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipeline_carry_skip_subtractor.sv
// Randomized and directed bench for pipeline_carry_skip_subtractor against a wide-arithmetic model.
module tb_pipeline_carry_skip_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   lat_on   = 1'b1;

    pipeline_carry_skip_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp_v);
    endtask

    // Reference: unsigned 65-bit and signed 66-bit arithmetic on the raw operands.
    function automatic exp_t ref_sub(input logic [63:0] x, input logic [63:0] y, input logic bi);
        exp_t               e;
        logic [64:0]        u;
        logic signed [65:0] s;
        u     = {1'b0, x} - {1'b0, y} - {64'd0, bi};
        s     = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - $signed({65'd0, bi});
        e.d   = u[63:0];
        e.bo  = u[64];
        e.ov  = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
        e.acc = cyc;
        return e;
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input bit iv, input logic [63:0] ia, input logic [63:0] ib,
                        input bit ibin, input bit ordy, output bit accepted);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
        check_val("in_ready", {63'd0, in_ready}, (out_valid && !ordy) ? 64'd0 : 64'd1);
        accepted = iv && in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = exp_q[0];
                check_val("diff", diff, e.d);
                check_val("bout", {63'd0, bout}, {63'd0, e.bo});
                check_val("ovf", {63'd0, ovf}, {63'd0, e.ov});
                if (ordy) begin
                    if (lat_on) check_val("latency", 64'(cyc - e.acc), 64'd3);
                    void'(exp_q.pop_front());
                end
            end
        end
        if (accepted) exp_q.push_back(ref_sub(ia, ib, ibin));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
        check_val("drain_left", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
    endtask

    logic [63:0] da [7];
    logic [63:0] db [7];
    bit          dbin [7];
    logic [63:0] sa [10];
    logic [63:0] sb [10];
    bit          sbin [10];

    initial begin
        bit acc;
        int idx;
        int t0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 64'd0;
        b         = 64'd0;
        bin       = 1'b0;
        out_ready = 1'b1;
        #3;
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_diff", diff, 64'd0);
        check_val("rst_bout", {63'd0, bout}, 64'd0);
        check_val("rst_ovf", {63'd0, ovf}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        da[0] = 64'd5;                  db[0] = 64'd3;                  dbin[0] = 1'b0;
        da[1] = 64'd0;                  db[1] = 64'd1;                  dbin[1] = 1'b0;
        da[2] = 64'h0000_0000_00FF_FFFF; db[2] = 64'd0;                  dbin[2] = 1'b1;
        da[3] = 64'h0000_0000_0100_0000; db[3] = 64'd1;                  dbin[3] = 1'b0;
        da[4] = 64'h8000_0000_0000_0000; db[4] = 64'd1;                  dbin[4] = 1'b0;
        da[5] = 64'h7FFF_FFFF_FFFF_FFFF; db[5] = 64'hFFFF_FFFF_FFFF_FFFF; dbin[5] = 1'b0;
        da[6] = 64'h0000_FFFF_FFFF_FFFF; db[6] = 64'h0000_FFFF_FFFF_FFFF; dbin[6] = 1'b1;

        lat_on = 1'b1;
        step(1'b1, da[0], db[0], dbin[0], 1'b1, acc);
        drain();
        for (int i = 1; i < 7; i++) step(1'b1, da[i], db[i], dbin[i], 1'b1, acc);
        drain();

        for (int i = 0; i < 10; i++) begin
            sa[i]   = {$urandom, $urandom};
            sb[i]   = {$urandom, $urandom};
            sbin[i] = $urandom_range(0, 1);
        end
        for (int i = 0; i < 10; i++) step(1'b1, sa[i], sb[i], sbin[i], 1'b1, acc);
        drain();

        lat_on = 1'b0;
        idx    = 0;
        t0     = cyc;
        for (int g = 0; g < 100 && idx < 10; g++) begin
            step(1'b1, sa[idx], sb[idx], sbin[idx],
                 !((cyc - t0) >= 4 && (cyc - t0) <= 7), acc);
            if (acc) idx++;
        end
        check_val("stall_accepted", 64'(idx), 64'd10);
        drain();

        for (int i = 0; i < 80; i++)
            step($urandom_range(0, 1), {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 1), $urandom_range(0, 3) != 0, acc);
        drain();

        lat_on = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, sa[i], sb[i], sbin[i], 1'b1, acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("arst_diff", diff, 64'd0);
        check_val("arst_bout", {63'd0, bout}, 64'd0);
        check_val("arst_ovf", {63'd0, ovf}, 64'd0);
        check_val("arst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, sa[5], sb[5], sbin[5], 1'b1, acc);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
